alu_decode_stage: RTL and testbench
===================================

ALU_DECODE_STAGE -- requirements
Module: alu_decode_stage

Interface
REQ-001 Parameter: CNT_W, default 8, width of the illegal-instruction counter.
REQ-002 clk  input  1  clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  instr holds a valid instruction.
REQ-005 in_ready  output  1  stage accepts instr this cycle.
REQ-006 instr  input  32  RV32I instruction word.
REQ-007 out_valid  output  1  decoded bundle valid.
REQ-008 out_ready  input  1  downstream accepts the bundle this cycle.
REQ-009 alu_op  output  4  ALU operation code; the ALU consumes it.
REQ-010 rs1, rs2, rd  output  5 each  register indices.
REQ-011 imm  output  32  decoded immediate.
REQ-012 use_imm  output  1  ALU second operand is imm, not rs2 data.
REQ-013 illegal  output  1  bundle is an unsupported or illegal encoding.
REQ-014 err_count  output  CNT_W  count of illegal bundles accepted by downstream.

Function
REQ-015 Stage SHALL be one pipeline register: in_ready = !out_valid || out_ready.
- Transfer in: in_valid && in_ready.
- Transfer out: out_valid && out_ready.
REQ-016 On transfer in, all bundle outputs SHALL update on the next edge; latency is exactly 1 cycle.
REQ-017 out_valid SHALL go 1 on transfer in; it SHALL go 0 on transfer out without a simultaneous transfer in.
REQ-018 Simultaneous transfer in and transfer out SHALL replace the bundle, with out_valid staying 1 and no bubble.
REQ-019 While out_valid=1 and out_ready=0, all bundle outputs SHALL hold stable.
REQ-020 alu_op encoding:
- ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100
- XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001
- PASS_B 1111
REQ-021 OP (opcode 0110011) SHALL decode as follows:
- funct7=0000000: funct3 000/001/010/011/100/101/110/111 SHALL give ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
- funct7=0100000: funct3 000 SHALL give SUB; funct3 101 SHALL give SRA.
- All other funct7/funct3 combinations SHALL be illegal.
- use_imm=0, imm=0.
REQ-022 OP-IMM (opcode 0010011) SHALL decode with the same funct3 mapping, SUB excluded, and use_imm=1.
- imm = sign-extended instr[31:20].
- Shifts: funct3 001 requires funct7=0000000; funct3 101 requires funct7 0000000 (SRL) or 0100000 (SRA); any other funct7 SHALL be illegal.
- Shift imm = zero-extended instr[24:20].
- rs2 = 0.
REQ-023 LUI (opcode 0110111) SHALL give alu_op=PASS_B, use_imm=1, imm={instr[31:12],12'b0}, rs1=0, rs2=0.
REQ-024 Any other opcode SHALL be illegal.
REQ-025 An illegal bundle SHALL carry illegal=1, alu_op=0000, use_imm=0, imm=0, with rs1, rs2 and rd taken from the raw instr fields.
REQ-026 err_count SHALL increment by 1 on each transfer out with illegal=1 and SHALL saturate at all-ones (no wrap).
REQ-027 No output SHALL depend combinationally on instr; only in_ready SHALL depend combinationally on out_ready.

Reset
REQ-028 With rst_n=0 at an edge, the block SHALL set out_valid=0, err_count=0, alu_op=0, rs1=rs2=rd=0, imm=0, use_imm=0, illegal=0.
REQ-029 A reset mid-stall SHALL discard the held bundle; in_ready SHALL be 1 on the first cycle after reset.

Verification
REQ-030 instr=0x002081B3 (ADD x3,x1,x2), out_ready=1 -> next cycle: out_valid=1, alu_op=0000, rs1=1, rs2=2, rd=3, use_imm=0, illegal=0.
REQ-031 instr=0xFFF00293 (ADDI x5,x0,-1) -> alu_op=0000, imm=0xFFFFFFFF, use_imm=1, rs1=0, rd=5.
REQ-032 instr=0x4030D093 (SRAI x1,x1,3) -> alu_op=0111, imm=0x00000003; instr=0x123453B7 (LUI x7,0x12345) -> alu_op=1111, imm=0x12345000, rd=7.
REQ-033 Stall: hold out_ready=0 for 5 cycles after a bundle is accepted -> outputs stable and in_ready=0 throughout; then raise out_ready with in_valid=1 -> back-to-back transfer with no bubble.
REQ-034 Drive instr=0x00000000 three times, then with CNT_W=2 drive it five times -> illegal=1 and err_count=3; the saturating run ends at 3.
REQ-035 Assert rst_n=0 during a stall -> out_valid=0 and err_count=0 on the next cycle.

Source files
------------

// File: rtl/alu_decode_stage.sv
// alu_decode_stage: RV32I decode for the ALU subset (OP, OP-IMM, LUI) behind
// a single valid/ready pipeline register, with a saturating count of the
// illegal bundles handed downstream.
module alu_decode_stage #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [3:0]       alu_op,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [31:0]      imm,
   output logic             use_imm,
   output logic             illegal,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [3:0] ALU_ADD   = 4'b0000;
   localparam logic [3:0] ALU_SUB   = 4'b0001;
   localparam logic [3:0] ALU_SLL   = 4'b0010;
   localparam logic [3:0] ALU_SLT   = 4'b0011;
   localparam logic [3:0] ALU_SLTU  = 4'b0100;
   localparam logic [3:0] ALU_XOR   = 4'b0101;
   localparam logic [3:0] ALU_SRL   = 4'b0110;
   localparam logic [3:0] ALU_SRA   = 4'b0111;
   localparam logic [3:0] ALU_OR    = 4'b1000;
   localparam logic [3:0] ALU_AND   = 4'b1001;
   localparam logic [3:0] ALU_PASSB = 4'b1111;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   localparam logic [6:0] F7_BASE   = 7'b0000000;
   localparam logic [6:0] F7_ALT    = 7'b0100000;

   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   // Shared funct3 -> ALU op mapping for the funct7=0 flavour of OP and OP-IMM
   function automatic logic [3:0] baseAluOp(input logic [2:0] f3);
      case (f3)
         3'b000:  baseAluOp = ALU_ADD;
         3'b001:  baseAluOp = ALU_SLL;
         3'b010:  baseAluOp = ALU_SLT;
         3'b011:  baseAluOp = ALU_SLTU;
         3'b100:  baseAluOp = ALU_XOR;
         3'b101:  baseAluOp = ALU_SRL;
         3'b110:  baseAluOp = ALU_OR;
         default: baseAluOp = ALU_AND;
      endcase
   endfunction

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic [6:0]       funct7;

   logic [3:0]       aluOpD, aluOpQ;
   logic [4:0]       rs1D, rs1Q;
   logic [4:0]       rs2D, rs2Q;
   logic [4:0]       rdD, rdQ;
   logic [31:0]      immD, immQ;
   logic             useImmD, useImmQ;
   logic             illegalD, illegalQ;
   logic             validD, validQ;
   logic [CNT_W-1:0] errCountD, errCountQ;

   logic             xferIn;
   logic             xferOut;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];

   assign in_ready = !validQ || out_ready;
   assign xferIn   = in_valid && in_ready;
   assign xferOut  = validQ && out_ready;

   // Decode the incoming word into the bundle that will be registered on accept
   always_comb begin
      aluOpD   = ALU_ADD;
      rs1D     = instr[19:15];
      rs2D     = instr[24:20];
      rdD      = instr[11:7];
      immD     = '0;
      useImmD  = 1'b0;
      illegalD = 1'b0;
      case (opcode)
         OPC_OP: begin
            if (funct7 == F7_BASE) begin
               aluOpD = baseAluOp(funct3);
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               aluOpD = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               aluOpD = ALU_SRA;
            end else begin
               illegalD = 1'b1;
            end
         end
         OPC_OPIMM: begin
            useImmD = 1'b1;
            rs2D    = '0;
            aluOpD  = baseAluOp(funct3);
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               immD = {27'b0, instr[24:20]};
               if (funct3 == 3'b101 && funct7 == F7_ALT) begin
                  aluOpD = ALU_SRA;
               end else if (funct7 != F7_BASE) begin
                  illegalD = 1'b1;
               end
            end else begin
               immD = {{20{instr[31]}}, instr[31:20]};
            end
         end
         OPC_LUI: begin
            aluOpD  = ALU_PASSB;
            useImmD = 1'b1;
            immD    = {instr[31:12], 12'b0};
            rs1D    = '0;
            rs2D    = '0;
         end
         default: begin
            illegalD = 1'b1;
         end
      endcase
      if (illegalD) begin
         aluOpD  = ALU_ADD;
         immD    = '0;
         useImmD = 1'b0;
         rs1D    = instr[19:15];
         rs2D    = instr[24:20];
      end
   end

   // Occupancy and saturating illegal-bundle counter for the next edge
   always_comb begin
      validD    = validQ;
      errCountD = errCountQ;
      if (xferIn) begin
         validD = 1'b1;
      end else if (xferOut) begin
         validD = 1'b0;
      end
      if (xferOut && illegalQ && errCountQ != '1) begin
         errCountD = errCountQ + CNT_ONE;
      end
   end

   // Pipeline register: bundle loads only on accept so a stall holds it steady
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         validQ    <= 1'b0;
         errCountQ <= '0;
         aluOpQ    <= '0;
         rs1Q      <= '0;
         rs2Q      <= '0;
         rdQ       <= '0;
         immQ      <= '0;
         useImmQ   <= 1'b0;
         illegalQ  <= 1'b0;
      end else begin
         validQ    <= validD;
         errCountQ <= errCountD;
         if (xferIn) begin
            aluOpQ   <= aluOpD;
            rs1Q     <= rs1D;
            rs2Q     <= rs2D;
            rdQ      <= rdD;
            immQ     <= immD;
            useImmQ  <= useImmD;
            illegalQ <= illegalD;
         end
      end
   end

   assign out_valid = validQ;
   assign alu_op    = aluOpQ;
   assign rs1       = rs1Q;
   assign rs2       = rs2Q;
   assign rd        = rdQ;
   assign imm       = immQ;
   assign use_imm   = useImmQ;
   assign illegal   = illegalQ;
   assign err_count = errCountQ;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage: directed and randomized stimulus for alu_decode_stage,
// checked by a queue-based scoreboard against a behavioural decode model.
module tb_alu_decode_stage;

   typedef struct packed {
      logic [3:0]  aluOp;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        useImm;
      logic        illegal;
   } bundle_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  alu_op;
   logic [4:0]  rs1, rs2, rd;
   logic [31:0] imm;
   logic        use_imm;
   logic        illegal;
   logic [7:0]  err_count;

   logic        satInReady;
   logic        satOutValid;
   logic [3:0]  satAluOp;
   logic [4:0]  satRs1, satRs2, satRd;
   logic [31:0] satImm;
   logic        satUseImm;
   logic        satIllegal;
   logic [1:0]  satErrCount;

   int          checks = 0;
   int          errors = 0;
   int          modelErr = 0;
   int          modelErr2 = 0;
   bit          inReset = 1'b1;
   bundle_t     expQ[$];
   bundle_t     popped;

   always #5 clk = ~clk;

   alu_decode_stage #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .out_valid(out_valid), .out_ready(out_ready),
      .alu_op(alu_op), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
      .use_imm(use_imm), .illegal(illegal), .err_count(err_count)
   );

   alu_decode_stage #(.CNT_W(2)) dutSat (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(satInReady),
      .instr(instr), .out_valid(satOutValid), .out_ready(out_ready),
      .alu_op(satAluOp), .rs1(satRs1), .rs2(satRs2), .rd(satRd), .imm(satImm),
      .use_imm(satUseImm), .illegal(satIllegal), .err_count(satErrCount)
   );

   // Reference decode built from the instruction-set rules with plain arithmetic
   function automatic bundle_t refDecode(input logic [31:0] w);
      bundle_t    b;
      logic [3:0] baseOp [8];
      logic [2:0] f3;
      logic [6:0] f7;
      int         sImm;
      bit         ok;
      baseOp = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
      f3 = w[14:12];
      f7 = w[31:25];
      b = '0;
      b.rd  = w[11:7];
      b.rs1 = w[19:15];
      b.rs2 = w[24:20];
      ok = 1'b0;
      if (w[6:0] == 7'h33) begin
         if (f7 == 7'h00) begin
            ok = 1'b1; b.aluOp = baseOp[f3];
         end else if (f7 == 7'h20 && f3 == 3'd0) begin
            ok = 1'b1; b.aluOp = 4'd1;
         end else if (f7 == 7'h20 && f3 == 3'd5) begin
            ok = 1'b1; b.aluOp = 4'd7;
         end
      end else if (w[6:0] == 7'h13) begin
         b.useImm = 1'b1;
         b.rs2 = 5'd0;
         if (f3 == 3'd1 || f3 == 3'd5) begin
            b.imm = 32'(w[24:20]);
            ok = (f7 == 7'h00) || (f3 == 3'd5 && f7 == 7'h20);
            b.aluOp = (f3 == 3'd5 && f7 == 7'h20) ? 4'd7 : baseOp[f3];
         end else begin
            sImm = int'(w[31:20]);
            if (sImm >= 2048) sImm = sImm - 4096;
            b.imm = sImm;
            ok = 1'b1;
            b.aluOp = baseOp[f3];
         end
      end else if (w[6:0] == 7'h37) begin
         ok = 1'b1;
         b.aluOp = 4'd15;
         b.useImm = 1'b1;
         b.imm = int'(w[31:12]) * 4096;
         b.rs1 = 5'd0;
         b.rs2 = 5'd0;
      end
      if (!ok) begin
         b = '0;
         b.illegal = 1'b1;
         b.rd  = w[11:7];
         b.rs1 = w[19:15];
         b.rs2 = w[24:20];
      end
      return b;
   endfunction

   function automatic bundle_t dutBundle();
      return {alu_op, rs1, rs2, rd, imm, use_imm, illegal};
   endfunction

   // Random instruction biased towards the supported opcodes and funct7 values
   function automatic logic [31:0] randInstr();
      logic [31:0] w;
      int          sel;
      int          f7sel;
      w = $urandom;
      sel = $urandom_range(0, 9);
      f7sel = $urandom_range(0, 3);
      if (sel <= 3) w[6:0] = 7'h33;
      else if (sel <= 6) w[6:0] = 7'h13;
      else if (sel == 7) w[6:0] = 7'h37;
      if (sel <= 6) begin
         if (f7sel <= 1) w[31:25] = 7'h00;
         else if (f7sel == 2) w[31:25] = 7'h20;
      end
      return w;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] w, input logic rdy);
      in_valid  = 1'b1;
      instr     = w;
      out_ready = rdy;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
   endtask

   // Scoreboard monitor: sampled on the falling edge, ahead of the next handshake
   always @(negedge clk) begin
      if (!rst_n) begin
         expQ.delete();
         modelErr  = 0;
         modelErr2 = 0;
         inReset   = 1'b1;
      end else begin
         if (inReset) begin
            checkOutput("resetBundle", 64'(dutBundle()), 64'(0));
            checkOutput("resetValid", 64'(out_valid), 64'(0));
            inReset = 1'b0;
         end
         checkOutput("inReady", 64'(in_ready), 64'(!out_valid || out_ready));
         checkOutput("errCount", 64'(err_count), 64'(modelErr));
         checkOutput("errCountSat", 64'(satErrCount), 64'(modelErr2));
         checkOutput("occupancy", 64'(out_valid), 64'(expQ.size()));
         if (out_valid && expQ.size() > 0) begin
            checkOutput("bundle", 64'(dutBundle()), 64'(expQ[0]));
         end
         if (out_valid && out_ready && expQ.size() > 0) begin
            popped = expQ.pop_front();
            if (popped.illegal) begin
               if (modelErr < 255) modelErr++;
               if (modelErr2 < 3) modelErr2++;
            end
         end
         if (in_valid && in_ready) begin
            expQ.push_back(refDecode(instr));
         end
      end
   end

   // Directed scenarios first, then a long randomized run
   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; instr = '0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("rstValid", 64'(out_valid), 64'(0));
      checkOutput("rstReady", 64'(in_ready), 64'(1));
      checkOutput("rstErr", 64'(err_count), 64'(0));
      rst_n = 1'b1;

      applyStimulus(32'h002081B3, 1'b1);
      checkOutput("addValid", 64'(out_valid), 64'(1));
      checkOutput("addOp", 64'(alu_op), 64'(0));
      checkOutput("addRegs", 64'({rs1, rs2, rd}), 64'({5'd1, 5'd2, 5'd3}));
      checkOutput("addFlags", 64'({use_imm, illegal}), 64'(0));

      applyStimulus(32'hFFF00293, 1'b1);
      checkOutput("addiOp", 64'(alu_op), 64'(0));
      checkOutput("addiImm", 64'(imm), 64'(32'hFFFFFFFF));
      checkOutput("addiUseImm", 64'(use_imm), 64'(1));
      checkOutput("addiRegs", 64'({rs1, rd}), 64'({5'd0, 5'd5}));

      applyStimulus(32'h4030D093, 1'b1);
      checkOutput("sraiOp", 64'(alu_op), 64'(7));
      checkOutput("sraiImm", 64'(imm), 64'(3));

      applyStimulus(32'h123453B7, 1'b1);
      checkOutput("luiOp", 64'(alu_op), 64'(15));
      checkOutput("luiImm", 64'(imm), 64'(32'h12345000));
      checkOutput("luiRd", 64'(rd), 64'(7));

      @(posedge clk);
      #1;
      applyStimulus(32'h002081B3, 1'b0);
      in_valid = 1'b1;
      instr = 32'h40208233;
      for (int i = 0; i < 5; i++) begin
         checkOutput("stallReady", 64'(in_ready), 64'(0));
         checkOutput("stallValid", 64'(out_valid), 64'(1));
         checkOutput("stallHold", 64'(dutBundle()), 64'(refDecode(32'h002081B3)));
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      checkOutput("b2bValid", 64'(out_valid), 64'(1));
      checkOutput("b2bOp", 64'(alu_op), 64'(1));
      checkOutput("b2bRd", 64'(rd), 64'(4));
      @(posedge clk);
      #1;

      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'h00000000, 1'b1);
         checkOutput("zeroIllegal", 64'(illegal), 64'(1));
         checkOutput("zeroOp", 64'(alu_op), 64'(0));
      end
      @(posedge clk);
      #1;
      checkOutput("errThree", 64'(err_count), 64'(3));
      checkOutput("errThreeSat", 64'(satErrCount), 64'(3));
      for (int i = 0; i < 5; i++) begin
         applyStimulus(32'h00000000, 1'b1);
      end
      @(posedge clk);
      #1;
      checkOutput("errEight", 64'(err_count), 64'(8));
      checkOutput("errSaturated", 64'(satErrCount), 64'(3));

      applyStimulus(32'h002081B3, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("midStallRstValid", 64'(out_valid), 64'(0));
      checkOutput("midStallRstErr", 64'(err_count), 64'(0));
      checkOutput("midStallRstReady", 64'(in_ready), 64'(1));
      rst_n = 1'b1;

      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 3) != 0);
         instr     = randInstr();
         rst_n     = ($urandom_range(0, 699) != 0);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("drainEmpty", 64'(expQ.size()), 64'(0));
      checkOutput("drainValid", 64'(out_valid), 64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
